mips_mc_core: RTL and testbench
===============================

Name: mips_mc_core

Overview:
Parametrised multicycle MIPS core that sequences fetch, decode, execute, memory and writeback through one FSM.
- Memory uses req/ack handshakes with arbitrary wait states, so instruction and data memories may stall.
- Drives an external register file (combinational read, synchronous write). The ALU is internal.
- Replaces the flat single-pass top. Adds stall tolerance, branches/jumps, PC wrap, illegal-opcode halt and retire reporting.

Parameters:
PC_W, 8, word-addressed PC width; instruction memory depth is 2^PC_W words
XLEN, 32, datapath and data-address width (instruction width fixed at 32)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
imem_req  out  1  instruction fetch request
imem_addr  out  PC_W  word address of fetch (= pc)
imem_ack  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  32  instruction word
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load; valid while dmem_req
dmem_addr  out  XLEN  byte address (ALU result)
dmem_wdata  out  XLEN  store data (rt value)
dmem_ack  in  1  access complete; dmem_rdata valid for loads
dmem_rdata  in  XLEN  load data
rf_ra1  out  5  read address A (instr[25:21])
rf_ra2  out  5  read address B (instr[20:16])
rf_rd1  in  XLEN  read data A
rf_rd2  in  XLEN  read data B
rf_we  out  1  register write strobe
rf_wa  out  5  write address
rf_wd  out  XLEN  write data
pc  out  PC_W  current PC
retired  out  1  one-cycle pulse per completed instruction
halted  out  1  sticky; core stopped
illegal  out  1  sticky; halt caused by unsupported opcode/funct

Behaviour:
Reset:
- state=FETCH, pc=0, IR/A/B/ALUOut/MDR=0; run flag=0.
- All outputs 0; imem_req, dmem_req and rf_we are forced 0 while reset is asserted.
- run flag sets on the first clk edge after reset release. imem_req asserts from the next cycle.
- Reset mid-operation aborts immediately: requests drop asynchronously, no register write, pc=0.

States: FETCH, DECODE, EXEC, MEM, WB, HALT (encoding in package).
- FETCH: imem_req=1, imem_addr=pc, held stable until imem_ack. On ack: IR<=imem_rdata; pc<=pc+1 (mod 2^PC_W, 0xFF->0x00 at default); ->DECODE. Ack may arrive in the same cycle as req (zero-wait).
- DECODE: drive rf_ra1/rf_ra2; latch A=rf_rd1, B=rf_rd2; sign-extend imm16 to XLEN.
  - Supported: R-type (op 0x00; funct 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x2A slt signed), addi 0x08, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
  - Anything else: illegal=1, halted=1, ->HALT, no retire.
  - j: pc<=IR[PC_W-1:0], retire, ->FETCH.
  - otherwise ->EXEC.
- EXEC: ALUOut<=ALU(A, B or imm).
  - beq: if A==B then pc<=pc+imm[PC_W-1:0], two's-complement wrap, relative to the incremented pc. Retire, ->FETCH.
  - lw/sw ->MEM; R-type/addi ->WB.
- MEM: dmem_req=1, dmem_addr=ALUOut, dmem_we=(sw), dmem_wdata=B; held stable until dmem_ack.
  - sw: retire, ->FETCH.
  - lw: MDR<=dmem_rdata, ->WB.
- WB: one cycle.
  - rf_wa=rd (R-type) or rt (addi/lw); rf_wd=ALUOut or MDR.
  - rf_we=1 unless rf_wa==0 (write suppressed, still retires).
  - retire, ->FETCH.
- HALT: terminal until reset; no requests, retired=0.

Arithmetic and output rules:
- XLEN-bit wraparound; overflow ignored; shamt ignored.
- retired asserts in the cycle the completing state exits.
- Cycle counts with zero-wait memory: j 2, beq 3, sw 4, R-type/addi 4, lw 5. Each memory wait cycle adds 1.

Decomposition:
- Shared package mips_pkg:
  - state enum
  - opcode and funct localparams
  - alu_op_t enum {ADD, SUB, AND, OR, SLT}
  - sign-extend function
- Sub-module mips_alu: parametrised XLEN, combinational, ports a, b, op -> y, zero.
- FSM, PC and pipeline holding registers stay in mips_mc_core.

Test Plan:
- addi $1,$0,5 (0x20010005) then add $2,$1,$1 (0x00211020), zero-wait -> WB writes $1=5 then $2=10; retired pulses 4 cycles apart; pc=2.
- lw $3,4($1) (0x8C230004) with $1=8 and dmem_ack delayed 3 cycles -> dmem_req/addr=12/we=0 held stable 4 cycles; rf writes $3=dmem_rdata; total 8 cycles.
- beq $0,$0,-1 (0x1000FFFF) at pc=0x05 -> pc returns to 0x05; fetch at pc=0xFF with +1 -> imem_addr 0x00 next fetch.
- Opcode 0x3F word 0xFC000000 -> illegal=1, halted=1; no imem_req afterward until rst_n pulse, after which pc=0 and fetch resumes.
- add $0,$1,$1 -> rf_we stays 0, retired still pulses; sw with dmem_ack never returning, rst_n asserted mid-MEM -> dmem_req drops the same cycle, pc=0.
- j 0x10 (0x08000010) -> pc=0x10 after 2 cycles, no rf_we, no dmem_req.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS core: FSM states, opcode/funct
// encodings, ALU operations and immediate sign extension.
package mips_pkg;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_SLT
  } alu_op_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  // Wide result so callers can size-cast down to any XLEN up to 64.
  function automatic logic [63:0] sign_ext16(input logic [15:0] imm);
    return {{48{imm[15]}}, imm};
  endfunction

endpackage

// File: rtl/mips_alu.sv
// Combinational XLEN-bit ALU: add, sub, and, or, signed set-less-than.
module mips_alu
  import mips_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  alu_op_t         op,
  output logic [XLEN-1:0] y,
  output logic            zero
);

  always_comb begin
    y = '0;
    case (op)
      ALU_ADD: y = a + b;
      ALU_SUB: y = a - b;
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      ALU_SLT: y = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
      default: y = '0;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/mips_mc_core.sv
// Multicycle MIPS core: one FSM steps fetch/decode/execute/memory/writeback,
// tolerating wait states on both memory handshakes.
module mips_mc_core
  import mips_pkg::*;
#(
  parameter int PC_W = 8,
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [31:0]     imem_rdata,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_ack,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic [4:0]      rf_ra1,
  output logic [4:0]      rf_ra2,
  input  logic [XLEN-1:0] rf_rd1,
  input  logic [XLEN-1:0] rf_rd2,
  output logic            rf_we,
  output logic [4:0]      rf_wa,
  output logic [XLEN-1:0] rf_wd,
  output logic [PC_W-1:0] pc,
  output logic            retired,
  output logic            halted,
  output logic            illegal
);

  state_t          state_reg;
  logic [PC_W-1:0] pc_reg;
  logic [31:0]     ir_reg;
  logic [XLEN-1:0] a_reg;
  logic [XLEN-1:0] b_reg;
  logic [XLEN-1:0] alu_out_reg;
  logic [XLEN-1:0] mdr_reg;
  logic            run_reg;
  logic            illegal_reg;

  logic [5:0]      op;
  logic [5:0]      funct;
  logic [4:0]      rt;
  logic [4:0]      rd;
  logic [4:0]      wb_addr;
  logic [XLEN-1:0] imm_ext;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_y;
  logic            alu_zero;
  alu_op_t         alu_op;
  logic            legal;

  assign op      = ir_reg[31:26];
  assign funct   = ir_reg[5:0];
  assign rt      = ir_reg[20:16];
  assign rd      = ir_reg[15:11];
  assign imm_ext = XLEN'(sign_ext16(ir_reg[15:0]));

  always_comb begin
    legal  = 1'b0;
    alu_op = ALU_ADD;
    case (op)
      OP_RTYPE: begin
        legal = 1'b1;
        case (funct)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_SLT:  alu_op = ALU_SLT;
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI, OP_LW, OP_SW, OP_J: legal = 1'b1;
      OP_BEQ: begin
        legal  = 1'b1;
        alu_op = ALU_SUB;
      end
      default: legal = 1'b0;
    endcase
  end

  // R-type and beq compare registers; everything else uses the immediate.
  assign alu_b = (op == OP_RTYPE || op == OP_BEQ) ? b_reg : imm_ext;

  mips_alu #(.XLEN(XLEN)) u_alu (
    .a    (a_reg),
    .b    (alu_b),
    .op   (alu_op),
    .y    (alu_y),
    .zero (alu_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= S_FETCH;
      pc_reg      <= '0;
      ir_reg      <= '0;
      a_reg       <= '0;
      b_reg       <= '0;
      alu_out_reg <= '0;
      mdr_reg     <= '0;
      run_reg     <= 1'b0;
      illegal_reg <= 1'b0;
    end else if (!run_reg) begin
      run_reg <= 1'b1;
    end else begin
      case (state_reg)
        S_FETCH: begin
          if (imem_ack) begin
            ir_reg    <= imem_rdata;
            pc_reg    <= pc_reg + PC_W'(1);
            state_reg <= S_DECODE;
          end
        end
        S_DECODE: begin
          a_reg <= rf_rd1;
          b_reg <= rf_rd2;
          if (!legal) begin
            illegal_reg <= 1'b1;
            state_reg   <= S_HALT;
          end else if (op == OP_J) begin
            pc_reg    <= ir_reg[PC_W-1:0];
            state_reg <= S_FETCH;
          end else begin
            state_reg <= S_EXEC;
          end
        end
        S_EXEC: begin
          alu_out_reg <= alu_y;
          if (op == OP_BEQ) begin
            // pc already points past the branch, so the offset is relative to it.
            if (alu_zero) pc_reg <= pc_reg + imm_ext[PC_W-1:0];
            state_reg <= S_FETCH;
          end else if (op == OP_LW || op == OP_SW) begin
            state_reg <= S_MEM;
          end else begin
            state_reg <= S_WB;
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            if (op == OP_SW) begin
              state_reg <= S_FETCH;
            end else begin
              mdr_reg   <= dmem_rdata;
              state_reg <= S_WB;
            end
          end
        end
        S_WB:    state_reg <= S_FETCH;
        S_HALT:  state_reg <= S_HALT;
        default: state_reg <= S_HALT;
      endcase
    end
  end

  assign wb_addr = (op == OP_RTYPE) ? rd : rt;

  // Requests and strobes are gated by rst_n so they drop the instant reset asserts.
  assign imem_req   = rst_n && run_reg && (state_reg == S_FETCH);
  assign imem_addr  = pc_reg;
  assign dmem_req   = rst_n && (state_reg == S_MEM);
  assign dmem_we    = (state_reg == S_MEM) && (op == OP_SW);
  assign dmem_addr  = alu_out_reg;
  assign dmem_wdata = b_reg;
  assign rf_ra1     = ir_reg[25:21];
  assign rf_ra2     = ir_reg[20:16];
  assign rf_we      = rst_n && (state_reg == S_WB) && (wb_addr != 5'd0);
  assign rf_wa      = wb_addr;
  assign rf_wd      = (op == OP_LW) ? mdr_reg : alu_out_reg;
  assign pc         = pc_reg;
  assign halted     = (state_reg == S_HALT);
  assign illegal    = illegal_reg;

  assign retired = rst_n && (
      ((state_reg == S_DECODE) && legal && (op == OP_J)) ||
      ((state_reg == S_EXEC) && (op == OP_BEQ)) ||
      ((state_reg == S_MEM) && dmem_ack && (op == OP_SW)) ||
      (state_reg == S_WB));

endmodule

// File: tb/tb_mips_mc_core.sv
// Directed bench for mips_mc_core: behavioural imem/dmem with programmable
// wait states and an external register file around the core.
module tb_mips_mc_core;

  localparam int PC_W = 8;
  localparam int XLEN = 32;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_ack;
  logic [31:0]     imem_rdata;
  logic            dmem_req;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_ack;
  logic [XLEN-1:0] dmem_rdata;
  logic [4:0]      rf_ra1;
  logic [4:0]      rf_ra2;
  logic [XLEN-1:0] rf_rd1;
  logic [XLEN-1:0] rf_rd2;
  logic            rf_we;
  logic [4:0]      rf_wa;
  logic [XLEN-1:0] rf_wd;
  logic [PC_W-1:0] pc;
  logic            retired;
  logic            halted;
  logic            illegal;

  always #5 clk = ~clk;

  mips_mc_core #(.PC_W(PC_W), .XLEN(XLEN)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .dmem_req   (dmem_req),
    .dmem_we    (dmem_we),
    .dmem_addr  (dmem_addr),
    .dmem_wdata (dmem_wdata),
    .dmem_ack   (dmem_ack),
    .dmem_rdata (dmem_rdata),
    .rf_ra1     (rf_ra1),
    .rf_ra2     (rf_ra2),
    .rf_rd1     (rf_rd1),
    .rf_rd2     (rf_rd2),
    .rf_we      (rf_we),
    .rf_wa      (rf_wa),
    .rf_wd      (rf_wd),
    .pc         (pc),
    .retired    (retired),
    .halted     (halted),
    .illegal    (illegal)
  );

  // Memories and register file
  logic [31:0] imem [256];
  logic [31:0] dmem [64];
  logic [31:0] rf [32];
  int          iwait = 0;
  int          dwait = 0;
  bit          dnever = 1'b0;
  int          icnt = 0;
  int          dcnt = 0;

  assign imem_ack   = imem_req && (icnt >= iwait);
  assign imem_rdata = imem[imem_addr];
  assign dmem_ack   = dmem_req && !dnever && (dcnt >= dwait);
  assign dmem_rdata = dmem[dmem_addr[7:2]];
  assign rf_rd1     = (rf_ra1 == 5'd0) ? 32'd0 : rf[rf_ra1];
  assign rf_rd2     = (rf_ra2 == 5'd0) ? 32'd0 : rf[rf_ra2];

  always @(posedge clk) begin
    icnt <= (!imem_req || imem_ack) ? 0 : icnt + 1;
    dcnt <= (!dmem_req || dmem_ack) ? 0 : dcnt + 1;
    if (!rst_n) dmem[3] <= 32'hDEADBEEF;
    else if (dmem_req && dmem_ack && dmem_we) dmem[dmem_addr[7:2]] <= dmem_wdata;
    if (rf_we) rf[rf_wa] <= rf_wd;
  end

  // Transaction monitor, sampled on the falling edge
  int          cyc = 0;
  int          ret_cyc[$];
  logic [4:0]  wa_q[$];
  logic [31:0] wd_q[$];
  int          dreq_n = 0;
  int          ireq_n = 0;
  int          dstab_bad = 0;
  logic [31:0] daddr_seen = '0;
  logic        dwe_seen = 1'b0;
  logic [31:0] prev_daddr = '0;
  logic        prev_dreq = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (retired) begin
        ret_cyc.push_back(cyc);
        $display("retire cyc=%0d pc=%02h", cyc, pc);
      end
      if (rf_we) begin
        wa_q.push_back(rf_wa);
        wd_q.push_back(rf_wd);
        $display("rf write $%0d=%08h", rf_wa, rf_wd);
      end
      if (dmem_req) begin
        dreq_n     <= dreq_n + 1;
        daddr_seen <= dmem_addr;
        dwe_seen   <= dmem_we;
        if (prev_dreq && dmem_addr != prev_daddr) dstab_bad <= dstab_bad + 1;
      end
      if (imem_req) ireq_n <= ireq_n + 1;
    end
    prev_dreq  <= dmem_req;
    prev_daddr <= dmem_addr;
  end

  // Checking helpers
  int total = 0;
  int bad = 0;
  int rb, wb, db, sb, ib, rel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int ret_at(input int i);
    if (i < ret_cyc.size()) return ret_cyc[i];
    return -1000;
  endfunction

  function automatic int wa_at(input int i);
    if (i < wa_q.size()) return int'(wa_q[i]);
    return -1;
  endfunction

  function automatic logic [31:0] wd_at(input int i);
    if (i < wd_q.size()) return wd_q[i];
    return 32'hBAD0BAD0;
  endfunction

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_ret(input int n, input int budget, input string tag);
    int k = 0;
    while (ret_cyc.size() < n && k < budget) begin
      step();
      k++;
    end
    chk(tag, ret_cyc.size(), n);
  endtask

  task automatic wait_halt(input int budget, input string tag);
    int k = 0;
    while (!halted && k < budget) begin
      step();
      k++;
    end
    chk(tag, halted, 1'b1);
  endtask

  task automatic enter_reset();
    step();
    rst_n = 1'b0;
    for (int i = 0; i < 256; i++) imem[i] = 32'hFC000000;
  endtask

  task automatic release_reset(input int iw, input int dw, input bit dn);
    iwait  = iw;
    dwait  = dw;
    dnever = dn;
    repeat (2) step();
    rb = ret_cyc.size();
    wb = wa_q.size();
    db = dreq_n;
    sb = dstab_bad;
    ib = ireq_n;
    rst_n = 1'b1;
    rel = cyc;
  endtask

  logic [4:0]  exp_wa [8] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd6, 5'd7, 5'd8};
  logic [31:0] exp_wd [8] = '{32'hFFFFFFFD, 32'h5, 32'hFFFFFFF8, 32'h5,
                              32'hFFFFFFFD, 32'h1, 32'h0, 32'hFFFFFFF8};

  initial begin
    // addi then add, zero-wait; then illegal opcode halt
    enter_reset();
    imem[0] = 32'h20010005;
    imem[1] = 32'h00211020;
    repeat (2) step();
    chk("rst_imem_req", imem_req, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_rf_we", rf_we, 0);
    chk("rst_pc", pc, 0);
    chk("rst_retired", retired, 0);
    chk("rst_halted", halted, 0);
    release_reset(0, 0, 0);
    wait_ret(rb + 2, 40, "t1_retire_cnt");
    chk("t1_first_latency", ret_at(rb) - rel, 4);
    chk("t1_retire_gap", ret_at(rb + 1) - ret_at(rb), 4);
    chk("t1_wa0", wa_at(wb), 1);
    chk("t1_wd0", wd_at(wb), 32'd5);
    chk("t1_wa1", wa_at(wb + 1), 2);
    chk("t1_wd1", wd_at(wb + 1), 32'd10);
    chk("t1_pc", pc, 2);
    wait_halt(20, "t1_halt");
    chk("t1_illegal", illegal, 1);
    ib = ireq_n;
    repeat (5) step();
    chk("t1_no_fetch_halted", ireq_n - ib, 0);
    chk("t1_no_retire_illegal", ret_cyc.size() - rb, 2);
    chk("t1_halt_pc", pc, 3);
    step();
    rst_n = 1'b0;
    #1;
    chk("t1_rst_pc", pc, 0);
    chk("t1_rst_halted", halted, 0);
    chk("t1_rst_illegal", illegal, 0);

    // lw with dmem_ack delayed by three cycles
    enter_reset();
    imem[0] = 32'h20010008;
    imem[1] = 32'h8C230004;
    release_reset(0, 3, 0);
    wait_ret(rb + 2, 60, "t2_retire_cnt");
    chk("t2_lw_cycles", ret_at(rb + 1) - ret_at(rb), 8);
    chk("t2_wa", wa_at(wb + 1), 3);
    chk("t2_wd", wd_at(wb + 1), 32'hDEADBEEF);
    chk("t2_dreq_cycles", dreq_n - db, 4);
    chk("t2_daddr", daddr_seen, 32'd12);
    chk("t2_dwe", dwe_seen, 0);
    chk("t2_daddr_stable", dstab_bad - sb, 0);

    // j to 5, beq back onto itself; imem wait added later
    enter_reset();
    imem[0] = 32'h08000005;
    imem[5] = 32'h1000FFFF;
    release_reset(0, 0, 0);
    wait_ret(rb + 2, 40, "t3_retire_cnt");
    chk("t3_beq_cycles", ret_at(rb + 1) - ret_at(rb), 3);
    step();
    chk("t3_pc_loop", pc, 5);
    chk("t3_imem_addr", imem_addr, 5);
    iwait = 1;
    wait_ret(rb + 3, 40, "t3_retire_cnt2");
    chk("t3_beq_wait_cycles", ret_at(rb + 2) - ret_at(rb + 1), 4);
    chk("t3_no_rf_write", wa_q.size() - wb, 0);
    chk("t3_no_dmem", dreq_n - db, 0);

    // j 0xFF then addi at 0xFF, pc wraps to 0
    enter_reset();
    imem[0]   = 32'h080000FF;
    imem[255] = 32'h20040007;
    release_reset(0, 0, 0);
    wait_ret(rb + 1, 20, "t4_retire_cnt");
    chk("t4_j_latency", ret_at(rb) - rel, 2);
    step();
    chk("t4_pc_ff", pc, 8'hFF);
    chk("t4_imem_addr_ff", imem_addr, 8'hFF);
    wait_ret(rb + 2, 20, "t4_retire_cnt2");
    chk("t4_addi_cycles", ret_at(rb + 1) - ret_at(rb), 4);
    chk("t4_pc_wrap", pc, 0);
    chk("t4_wa", wa_at(wb), 4);
    chk("t4_wd", wd_at(wb), 32'd7);
    step();
    chk("t4_fetch_wrap_req", imem_req, 1);
    chk("t4_fetch_wrap_addr", imem_addr, 0);

    // ALU ops, sw/lw round trip, then illegal funct
    enter_reset();
    imem[0] = 32'h2001FFFD;
    imem[1] = 32'h20020005;
    imem[2] = 32'h00221822;
    imem[3] = 32'h00222024;
    imem[4] = 32'h00222825;
    imem[5] = 32'h0022302A;
    imem[6] = 32'h0041382A;
    imem[7] = 32'hAC030000;
    imem[8] = 32'h8C080000;
    imem[9] = 32'h00000021;
    release_reset(0, 0, 0);
    wait_ret(rb + 9, 120, "t5_retire_cnt");
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_wa%0d", i), wa_at(wb + i), exp_wa[i]);
      chk($sformatf("t5_wd%0d", i), wd_at(wb + i), exp_wd[i]);
    end
    chk("t5_sw_cycles", ret_at(rb + 7) - ret_at(rb + 6), 4);
    chk("t5_lw_cycles", ret_at(rb + 8) - ret_at(rb + 7), 5);
    wait_halt(20, "t5_halt");
    chk("t5_illegal_funct", illegal, 1);
    chk("t5_retire_total", ret_cyc.size() - rb, 9);

    // write to $0 suppressed; sw stalls forever and reset aborts it
    enter_reset();
    imem[0] = 32'h20010003;
    imem[1] = 32'h00210020;
    imem[2] = 32'hAC010010;
    release_reset(0, 0, 1);
    wait_ret(rb + 2, 40, "t6_retire_cnt");
    chk("t6_r0_write_suppressed", wa_q.size() - wb, 1);
    begin
      int k = 0;
      while (!dmem_req && k < 20) begin
        step();
        k++;
      end
    end
    chk("t6_dmem_req", dmem_req, 1);
    repeat (2) step();
    chk("t6_dmem_addr", dmem_addr, 32'd16);
    chk("t6_dmem_we", dmem_we, 1);
    chk("t6_dmem_wdata", dmem_wdata, 32'd3);
    rst_n = 1'b0;
    #1;
    chk("t6_abort_dmem_req", dmem_req, 0);
    chk("t6_abort_pc", pc, 0);
    chk("t6_abort_imem_req", imem_req, 0);
    chk("t6_no_sw_retire", ret_cyc.size() - rb, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
